// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU operand stage: default widths, FSM encoding, PSR layout.
package alu_stage_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_OP_W   = 8;
    localparam int unsigned PSR_W      = 5;

    localparam int unsigned PSR_C = 0;
    localparam int unsigned PSR_L = 1;
    localparam int unsigned PSR_F = 2;
    localparam int unsigned PSR_Z = 3;
    localparam int unsigned PSR_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    // Field order matches the PSR bit positions, N in the MSB down to C in the LSB.
    typedef struct packed {
        logic n;
        logic z;
        logic f;
        logic l;
        logic c;
    } psr_t;

    function automatic psr_t make_psr(input logic n, input logic z, input logic f,
                                      input logic l, input logic c);
        psr_t p;
        p.n = n;
        p.z = z;
        p.f = f;
        p.l = l;
        p.c = c;
        return p;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file with three combinational read ports and one muxed write port.
module alu_regfile
    import alu_stage_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [WIDTH-1:0]  ext_data,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [WIDTH-1:0]  a_data,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [WIDTH-1:0]  b_data,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [WIDTH-1:0]  d_data
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs_q [NREGS];

    // Writeback wins over an external load; the caller gates each enable by state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[wb_addr] <= wb_data;
        end else if (ext_we) begin
            regs_q[ext_addr] <= ext_data;
        end
    end

    assign a_data = regs_q[a_addr];
    assign b_data = regs_q[b_addr];
    assign d_data = regs_q[d_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Sequenced operand fetch / result writeback stage sitting in front of an external ALU.
module alu_operand_stage
    import alu_stage_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   opcode_in,
    input  logic [ADDR_W-1:0] rdest,
    input  logic [ADDR_W-1:0] rsrc,
    input  logic [WIDTH-1:0]  imm,
    input  logic              use_imm,
    input  logic              wb_en,
    input  logic              flags_we,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [WIDTH-1:0]  ext_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [WIDTH-1:0]  alu_c,
    input  logic              alu_carry,
    input  logic              alu_flag,
    input  logic              alu_low,
    input  logic              alu_negative,
    input  logic              alu_zero,
    output logic              busy,
    output logic              done,
    output logic [PSR_W-1:0]  psr
);

    state_t state_q, state_d;

    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] rdest_q, rsrc_q;
    logic [WIDTH-1:0]  imm_q;
    logic              use_imm_q, wb_en_q, flags_we_q;

    logic [WIDTH-1:0]  res_q;
    psr_t              flags_q;

    logic [WIDTH-1:0]  rf_a, rf_b;
    logic              accept, rf_wb_we, rf_ext_we;

    assign accept    = (state_q == ST_IDLE) && start;
    assign rf_wb_we  = (state_q == ST_WB) && wb_en_q;
    assign rf_ext_we = (state_q == ST_IDLE) && ext_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request fields are frozen at acceptance so inputs may change during the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            rdest_q    <= '0;
            rsrc_q     <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            wb_en_q    <= 1'b0;
            flags_we_q <= 1'b0;
        end else if (accept) begin
            op_q       <= opcode_in;
            rdest_q    <= rdest;
            rsrc_q     <= rsrc;
            imm_q      <= imm;
            use_imm_q  <= use_imm;
            wb_en_q    <= wb_en;
            flags_we_q <= flags_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            res_q      <= '0;
            flags_q    <= '0;
            psr        <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done <= (state_q == ST_WB);
            busy <= (state_d != ST_IDLE);
            if (state_q == ST_FETCH) begin
                alu_a      <= rf_a;
                alu_b      <= use_imm_q ? imm_q : rf_b;
                alu_opcode <= op_q;
            end
            if (state_q == ST_EXEC) begin
                res_q   <= alu_c;
                flags_q <= make_psr(alu_negative, alu_zero, alu_flag, alu_low, alu_carry);
            end
            if ((state_q == ST_WB) && flags_we_q) begin
                psr <= flags_q;
            end
        end
    end

    alu_regfile #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_we    (rf_wb_we),
        .wb_addr  (rdest_q),
        .wb_data  (res_q),
        .ext_we   (rf_ext_we),
        .ext_addr (ext_addr),
        .ext_data (ext_data),
        .a_addr   (rdest_q),
        .a_data   (rf_a),
        .b_addr   (rsrc_q),
        .b_data   (rf_b),
        .d_addr   (dbg_addr),
        .d_data   (dbg_data)
    );

endmodule
